// File: rtl/msk_svrs_pkg.sv
// msk_svrs_pkg: shared geometry, FSM states and share/column slicing helpers for the SVRS bridge
package msk_svrs_pkg;
  localparam int COL_W = 32;
  localparam int COLS = 4;
  localparam int BLK_W = COL_W * COLS;
  typedef enum logic {FILL, PRESENT} in_state_e;
  typedef enum logic {IDLE, DRAIN} out_state_e;
  function automatic int word_off(int j);
    return j * COL_W;
  endfunction
  function automatic int blk_off(int j, int k);
    return j * BLK_W + k * COL_W;
  endfunction
endpackage

// File: rtl/msk_svrs_block_to_words.sv
// msk_svrs_block_to_words: captures a masked ciphertext block and serializes it column by column
module msk_svrs_block_to_words
  import msk_svrs_pkg::*;
#(
  parameter int D = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_W*D-1:0] ct_data,
  input  logic               ct_valid,
  output logic               ct_ready,
  output logic [COL_W*D-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               active
);
  out_state_e state_q, state_d;
  logic [1:0] rcnt;
  logic [BLK_W*D-1:0] blk_q;
  logic ct_xfer, m_xfer;
  assign ct_xfer = ct_valid & ct_ready;
  assign m_xfer = m_valid & m_ready;
  assign active = state_q != IDLE;
  always_comb begin
    state_d = (state_q == IDLE) ? (ct_xfer ? DRAIN : IDLE)
                                : ((m_xfer && rcnt == 2'd3) ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt <= 2'd0;
      ct_ready <= 1'b1;
      m_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_ready <= state_d == IDLE;
      m_valid <= state_d == DRAIN;
      rcnt <= ct_xfer ? 2'd0 : (m_xfer ? rcnt + 2'd1 : rcnt);
    end
  end
  always_ff @(posedge clk) begin
    if (ct_xfer) blk_q <= ct_data;
  end
  // Output word is a mux of the captured block, so it is stable while rcnt holds
  always_comb begin
    m_data = '0;
    for (int j = 0; j < D; j++) m_data[word_off(j) +: COL_W] = blk_q[blk_off(j, int'(rcnt)) +: COL_W];
  end
endmodule

// File: rtl/msk_svrs_stream_bridge.sv
// msk_svrs_stream_bridge: packs masked word streams into SVRS blocks for the AES core and
// serializes masked ciphertext blocks back into words; shares are moved, never combined
module msk_svrs_stream_bridge
  import msk_svrs_pkg::*;
#(
  parameter int D = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COL_W*D-1:0] s_data,
  input  logic               s_inverse,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [BLK_W*D-1:0] blk_data,
  output logic               blk_inverse,
  output logic               blk_valid,
  input  logic               blk_ready,
  input  logic [BLK_W*D-1:0] ct_data,
  input  logic               ct_valid,
  output logic               ct_ready,
  output logic [COL_W*D-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
);
  in_state_e state_q, state_d;
  logic [1:0] wcnt;
  logic s_xfer, drain;
  assign s_xfer = s_valid & s_ready;
  assign busy = (state_q != FILL) | (wcnt != 2'd0) | drain;
  always_comb begin
    state_d = (state_q == FILL) ? ((s_xfer && wcnt == 2'd3) ? PRESENT : FILL)
                                : (blk_ready ? FILL : PRESENT);
  end
  // wcnt wraps to 0 on the fourth word, so it is already 0 when the block is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      wcnt <= 2'd0;
      s_ready <= 1'b1;
      blk_valid <= 1'b0;
      blk_inverse <= 1'b0;
    end else begin
      state_q <= state_d;
      s_ready <= state_d == FILL;
      blk_valid <= state_d == PRESENT;
      if (s_xfer) wcnt <= wcnt + 2'd1;
      if (s_xfer && wcnt == 2'd0) blk_inverse <= s_inverse;
    end
  end
  always_ff @(posedge clk) begin
    if (s_xfer)
      for (int j = 0; j < D; j++) blk_data[blk_off(j, int'(wcnt)) +: COL_W] <= s_data[word_off(j) +: COL_W];
  end
  msk_svrs_block_to_words #(.D(D)) u_egress (
    .clk(clk),
    .rst(rst),
    .ct_data(ct_data),
    .ct_valid(ct_valid),
    .ct_ready(ct_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .active(drain)
  );
endmodule

// File: tb/tb_msk_svrs_stream_bridge.sv
// tb_msk_svrs_stream_bridge: vector table for block packing plus scoreboarded egress and corner sequences
module tb_msk_svrs_stream_bridge;
  localparam int D = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] s_data = '0;
  logic s_inverse = 1'b0, s_valid = 1'b0, s_ready;
  logic [255:0] blk_data;
  logic blk_inverse, blk_valid, blk_ready = 1'b0;
  logic [255:0] ct_data = '0;
  logic ct_valid = 1'b0, ct_ready;
  logic [63:0] m_data;
  logic m_valid, m_ready = 1'b0, busy;

  msk_svrs_stream_bridge #(.D(D)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_inverse(s_inverse), .s_valid(s_valid), .s_ready(s_ready),
    .blk_data(blk_data), .blk_inverse(blk_inverse), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] words;
    logic inv;
    int hold;
    logic [255:0] exp;
  } vec_t;
  typedef struct packed {
    logic [255:0] data;
    logic inv;
  } blk_t;

  vec_t tab[3];
  blk_t blk_q[$];
  logic [63:0] m_q[$];
  logic [63:0] mw[4];
  logic minv = 1'b0;
  int checks = 0, errs = 0, blk_xfers = 0, m_mode = 0, mcnt = 0, dcnt = 0;
  bit ct_due = 0;
  logic prev_rst = 1'b1, prev_bv = 1'b0, prev_br = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0;
  logic [255:0] prev_bd = '0;
  logic [63:0] prev_md = '0;

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol checks against last cycle, plus scoreboard bookkeeping for the coming edge
  task automatic monitor();
    blk_t b;
    logic [63:0] w;
    if (!prev_rst && prev_bv && !prev_br) check(blk_valid && blk_data == prev_bd, "blk_hold", blk_data, prev_bd);
    if (!prev_rst && prev_mv && !prev_mr) check(m_valid && m_data == prev_md, "m_hold", 256'(m_data), 256'(prev_md));
    if (!prev_rst && ct_due) check(ct_ready, "ct_ready_after_drain", 256'(ct_ready), 256'(1));
    ct_due = 0;
    if (rst) begin
      blk_q.delete();
      m_q.delete();
      mcnt = 0;
      dcnt = 0;
    end else begin
      if (m_valid) check(!ct_ready, "ct_ready_in_drain", 256'(ct_ready), 256'(0));
      if (s_valid && s_ready) begin
        mw[mcnt] = s_data;
        if (mcnt == 0) minv = s_inverse;
        if (mcnt == 3)
          blk_q.push_back({mw[3][63:32], mw[2][63:32], mw[1][63:32], mw[0][63:32],
                           mw[3][31:0], mw[2][31:0], mw[1][31:0], mw[0][31:0], minv});
        mcnt = (mcnt + 1) % 4;
      end
      if (blk_valid && blk_ready) begin
        blk_xfers++;
        if (blk_q.size() == 0) check(0, "blk_unexpected", blk_data, '0);
        else begin
          b = blk_q.pop_front();
          check(blk_data == b.data && blk_inverse == b.inv, "blk_scoreboard", {blk_data[254:0], blk_inverse}, {b.data[254:0], b.inv});
        end
      end
      if (ct_valid && ct_ready) begin
        for (int k = 0; k < 4; k++) m_q.push_back({ct_data[128+32*k +: 32], ct_data[32*k +: 32]});
        dcnt = 0;
      end
      if (m_valid && m_ready) begin
        if (m_q.size() == 0) check(0, "m_unexpected", 256'(m_data), '0);
        else begin
          w = m_q.pop_front();
          check(m_data == w, "m_scoreboard", 256'(m_data), 256'(w));
        end
        dcnt++;
        if (dcnt == 4) begin
          ct_due = 1;
          dcnt = 0;
        end
      end
    end
    prev_rst = rst; prev_bv = blk_valid; prev_br = blk_ready; prev_bd = blk_data;
    prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    m_ready = (m_mode == 1) ? 1'($urandom_range(0, 1)) : (m_mode == 0);
  endtask

  task automatic run_vec(input int i);
    int n0 = blk_xfers;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data = tab[i].words[64*k +: 64];
      s_inverse = (k == 0) ? tab[i].inv : ~tab[i].inv;
      blk_ready = (k == 3 && tab[i].hold == 0);
      if (k == 3) check(!blk_valid, "blk_valid_early", 256'(blk_valid), 256'(0));
      step();
    end
    s_valid = 1'b0;
    check(blk_valid, "blk_valid_latency", 256'(blk_valid), 256'(1));
    check(blk_data == tab[i].exp, "blk_pack", blk_data, tab[i].exp);
    check(blk_inverse == tab[i].inv, "blk_inverse", 256'(blk_inverse), 256'(tab[i].inv));
    check(!s_ready, "s_ready_present", 256'(s_ready), 256'(0));
    for (int h = 0; h < tab[i].hold; h++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = {$urandom, $urandom};
      s_inverse = 1'($urandom_range(0, 1));
      step();
      check(!s_ready && blk_valid, "present_stall", 256'({s_ready, blk_valid}), 256'(2'b01));
    end
    s_valid = 1'b0;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    check(!blk_valid && s_ready, "blk_release", 256'({blk_valid, s_ready}), 256'(2'b01));
    check(blk_xfers - n0 == 1, "blk_count", 256'(blk_xfers - n0), 256'(1));
  endtask

  task automatic send_ct(input logic [255:0] d);
    int n = 0;
    bit ok;
    ct_data = d;
    ct_valid = 1'b1;
    do begin
      ok = ct_ready;
      step();
      n++;
    end while (!ok && n < 50);
    ct_valid = 1'b0;
    check(ok, "ct_accept", 256'(ok), 256'(1));
  endtask

  task automatic check_reset(input string name);
    check(s_ready && !blk_valid && !blk_inverse && ct_ready && !m_valid && !busy, name,
          256'({s_ready, blk_valid, blk_inverse, ct_ready, m_valid, busy}), 256'(6'b100100));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tab[0] = '{words: {64'h1c1d1e1f_0c0d0e0f, 64'h18191a1b_08090a0b, 64'h14151617_04050607, 64'h10111213_00010203},
               inv: 1'b1, hold: 0,
               exp: {128'h1c1d1e1f_18191a1b_14151617_10111213, 128'h0c0d0e0f_08090a0b_04050607_00010203}};
    tab[1] = '{words: {64'hB0000003_A0000003, 64'hB0000002_A0000002, 64'hB0000001_A0000001, 64'hB0000000_A0000000},
               inv: 1'b0, hold: 7,
               exp: {128'hB0000003_B0000002_B0000001_B0000000, 128'hA0000003_A0000002_A0000001_A0000000}};
    tab[2] = '{words: {64'h4B5A6978_00000000, 64'h0F1E2D3C_FFFFFFFF, 64'h9ABCDEF0_00000000, 64'h12345678_FFFFFFFF},
               inv: 1'b1, hold: 2,
               exp: {128'h4B5A6978_0F1E2D3C_9ABCDEF0_12345678, 128'h00000000_FFFFFFFF_00000000_FFFFFFFF}};
    repeat (3) step();
    rst = 1'b0;
    check_reset("reset_state");
    for (int i = 0; i < 3; i++) run_vec(i);
    m_mode = 0;
    send_ct({128'h11111111_22222222_33333333_44444444, 128'h55555555_66666666_77777777_88888888});
    check(m_valid, "m_latency", 256'(m_valid), 256'(1));
    n = 0;
    while (!ct_ready && n < 20) begin
      step();
      n++;
    end
    check(n == 4, "egress_cycles", 256'(n), 256'(4));
    check(!busy, "idle_busy", 256'(busy), 256'(0));
    m_mode = 1;
    send_ct({128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 128'hDEADBEEF_0BADF00D_CAFEBABE_C0FFEE00});
    n = 0;
    while ((!ct_ready || m_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check(n < 100, "random_drain_done", 256'(n), 256'(100));
    m_mode = 2;
    send_ct({128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A, 128'h01020304_05060708_090A0B0C_0D0E0F10});
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data = {$urandom, $urandom};
      s_inverse = 1'($urandom_range(0, 1));
      step();
      check(busy, "busy_concurrent", 256'(busy), 256'(1));
    end
    s_valid = 1'b0;
    check(blk_valid && m_valid, "overlap", 256'({blk_valid, m_valid}), 256'(2'b11));
    m_mode = 1;
    blk_ready = 1'b1;
    n = 0;
    while ((blk_valid || m_valid) && n < 100) begin
      check(busy, "busy_overlap", 256'(busy), 256'(1));
      step();
      n++;
    end
    blk_ready = 1'b0;
    check(blk_q.size() == 0 && m_q.size() == 0, "overlap_drained", 256'(blk_q.size() + m_q.size()), '0);
    m_mode = 2;
    send_ct({128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, 128'h12121212_34343434_56565656_78787878});
    m_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = {$urandom, $urandom};
      s_inverse = 1'b1;
      step();
    end
    s_valid = 1'b0;
    check(busy && m_valid, "busy_before_reset", 256'({busy, m_valid}), 256'(2'b11));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("mid_op_reset");
    m_mode = 0;
    run_vec(0);
    n = 0;
    while ((blk_q.size() != 0 || m_q.size() != 0 || m_valid) && n < 50) begin
      step();
      n++;
    end
    check(blk_q.size() == 0 && m_q.size() == 0 && !m_valid, "scoreboard_empty", 256'(blk_q.size() + m_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
